voice_allocator: RTL and testbench

- Schedules incoming notes onto three shared note-player voices for the harmonic chord path.
- Sits between the song reader's note/duration/new_note stream and the three per-voice note players.
- Tracks each voice's remaining beats, picks a free voice per note, and steals a voice when all three are busy.
- Reports per-voice load strobes and occupancy, plus chord-completion status back to the song reader.

---
 rtl/voice_allocator_if.sv | 28 ++
 rtl/voice_allocator.sv | 103 ++++++++++
 tb/tb_voice_allocator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note stream in, per-voice load/status out for the voice allocator
interface voice_allocator_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
);
  logic                  play;
  logic                  beat;
  logic                  new_note;
  logic [NOTE_W-1:0]     note;
  logic [DUR_W-1:0]      duration;
  logic [2:0]            load_voice;
  logic [3*NOTE_W-1:0]   voice_note;
  logic [2:0]            voice_active;
  logic                  steal;
  logic                  drop;
  logic                  all_idle;
  logic                  chord_done;

  modport slave (
    input  play, beat, new_note, note, duration,
    output load_voice, voice_note, voice_active, steal, drop, all_idle, chord_done
  );

  modport master (
    output play, beat, new_note, note, duration,
    input  load_voice, voice_note, voice_active, steal, drop, all_idle, chord_done
  );
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - schedules notes onto three shared voices with beat countdown and stealing
module voice_allocator #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  voice_allocator_if.slave   bus
);

  logic [DUR_W-1:0]    r_remaining [3];
  logic [3*NOTE_W-1:0] r_voice_note;
  logic [2:0]          r_load_voice;
  logic [2:0]          r_voice_active;
  logic                r_steal;
  logic                r_drop;
  logic                r_all_idle;
  logic                r_chord_done;

  logic                w_tick;
  logic                w_load;
  logic                w_drop;
  logic                w_free_found;
  logic [1:0]          w_free_idx;
  logic [1:0]          w_min_idx;
  logic [DUR_W-1:0]    w_min_val;
  logic [1:0]          w_sel;
  logic [DUR_W-1:0]    w_next_rem [3];
  logic [2:0]          w_next_active;
  logic [2:0]          w_load_onehot;

  // An expiring voice frees up this very edge, so it is preferred over stealing.
  always_comb begin
    w_tick       = bus.play & bus.beat;
    w_load       = bus.new_note && (bus.note != '0) && (bus.duration != '0);
    w_drop       = bus.new_note && (bus.duration == '0);
    w_free_found = 1'b0;
    w_free_idx   = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if ((r_remaining[i] == '0) || (w_tick && (r_remaining[i] == DUR_W'(1)))) begin
        w_free_found = 1'b1;
        w_free_idx   = 2'(i);
      end
    end
    w_min_idx = 2'd0;
    w_min_val = r_remaining[0];
    for (int i = 1; i < 3; i++) begin
      if (r_remaining[i] < w_min_val) begin
        w_min_idx = 2'(i);
        w_min_val = r_remaining[i];
      end
    end
    w_sel = w_free_found ? w_free_idx : w_min_idx;
  end

  always_comb begin
    w_load_onehot = 3'b000;
    w_next_active = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_next_rem[i] = r_remaining[i];
      if (w_load && (w_sel == 2'(i))) begin
        w_next_rem[i]    = bus.duration;
        w_load_onehot[i] = 1'b1;
      end else if (w_tick && (r_remaining[i] != '0)) begin
        w_next_rem[i] = r_remaining[i] - DUR_W'(1);
      end
      w_next_active[i] = (w_next_rem[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) r_remaining[i] <= '0;
      r_voice_note   <= '0;
      r_load_voice   <= 3'b000;
      r_voice_active <= 3'b000;
      r_steal        <= 1'b0;
      r_drop         <= 1'b0;
      r_all_idle     <= 1'b1;
      r_chord_done   <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_remaining[i] <= w_next_rem[i];
        if (w_load_onehot[i]) r_voice_note[i*NOTE_W +: NOTE_W] <= bus.note;
      end
      r_load_voice   <= w_load_onehot;
      r_voice_active <= w_next_active;
      r_steal        <= w_load && !w_free_found;
      r_drop         <= w_drop;
      r_all_idle     <= (w_next_active == 3'b000);
      r_chord_done   <= !r_all_idle && (w_next_active == 3'b000);
    end
  end

  assign bus.load_voice   = r_load_voice;
  assign bus.voice_note   = r_voice_note;
  assign bus.voice_active = r_voice_active;
  assign bus.steal        = r_steal;
  assign bus.drop         = r_drop;
  assign bus.all_idle     = r_all_idle;
  assign bus.chord_done   = r_chord_done;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed and random checks of voice_allocator against a behavioural model
module tb_voice_allocator;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  int   m_rem [3];
  int   m_note [3];
  bit   m_idle;
  int   e_load, e_active, e_steal, e_drop, e_idle, e_chord;
  logic [17:0] e_notes;

  voice_allocator_if #(.NOTE_W(6), .DUR_W(6)) bus ();
  voice_allocator #(.NOTE_W(6), .DUR_W(6)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rem[i] = 0;
      m_note[i] = 0;
    end
    m_idle = 1'b1;
    e_load = 0; e_active = 0; e_steal = 0; e_drop = 0; e_idle = 1; e_chord = 0;
    e_notes = '0;
  endtask

  // Higher-level rules: pick first voice that is free or about to finish; else the shortest remaining.
  task automatic model_step(input bit nn, input int note, input int dur, input bit beat, input bit play);
    bit tick;
    int sel;
    tick = beat && play;
    sel = -1;
    e_steal = 0;
    e_drop = (nn && dur == 0) ? 1 : 0;
    if (nn && note != 0 && dur != 0) begin
      for (int i = 0; i < 3 && sel < 0; i++)
        if (m_rem[i] == 0 || (tick && m_rem[i] == 1)) sel = i;
      if (sel < 0) begin
        sel = 0;
        for (int i = 1; i < 3; i++) if (m_rem[i] < m_rem[sel]) sel = i;
        e_steal = 1;
      end
    end
    e_active = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == sel) begin
        m_rem[i] = dur;
        m_note[i] = note;
      end else if (tick && m_rem[i] > 0) begin
        m_rem[i] = m_rem[i] - 1;
      end
      if (m_rem[i] != 0) e_active += (1 << i);
    end
    e_load = (sel >= 0) ? (1 << sel) : 0;
    e_notes = {6'(m_note[2]), 6'(m_note[1]), 6'(m_note[0])};
    e_chord = (!m_idle && e_active == 0) ? 1 : 0;
    m_idle = (e_active == 0);
    e_idle = m_idle ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".load_voice"}, 32'(bus.load_voice), 32'(e_load));
    chk({tag, ".voice_note"}, 32'(bus.voice_note), 32'(e_notes));
    chk({tag, ".voice_active"}, 32'(bus.voice_active), 32'(e_active));
    chk({tag, ".steal"}, 32'(bus.steal), 32'(e_steal));
    chk({tag, ".drop"}, 32'(bus.drop), 32'(e_drop));
    chk({tag, ".all_idle"}, 32'(bus.all_idle), 32'(e_idle));
    chk({tag, ".chord_done"}, 32'(bus.chord_done), 32'(e_chord));
  endtask

  task automatic cyc(input string tag, input bit nn, input int note, input int dur,
                     input bit beat, input bit play);
    bus.new_note = nn;
    bus.note     = 6'(note);
    bus.duration = 6'(dur);
    bus.beat     = beat;
    bus.play     = play;
    @(posedge clk);
    model_step(nn, note, dur, beat, play);
    #1;
    check_all(tag);
    bus.new_note = 1'b0;
    bus.beat     = 1'b0;
  endtask

  initial begin
    bus.play = 1'b1; bus.beat = 1'b0; bus.new_note = 1'b0; bus.note = '0; bus.duration = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    bus.new_note = 1'b1; bus.note = 6'd10; bus.duration = 6'd4;
    @(posedge clk);
    #1;
    bus.new_note = 1'b0;
    rst_n = 1'b1;
    check_all("reset");
    chk("reset.all_idle_const", 32'(bus.all_idle), 32'd1);
    chk("reset.load_const", 32'(bus.load_voice), 32'd0);

    cyc("fill0", 1, 5, 3, 0, 1);
    chk("fill0.lv", 32'(bus.load_voice), 32'b001);
    cyc("fill1", 1, 7, 5, 0, 1);
    chk("fill1.lv", 32'(bus.load_voice), 32'b010);
    cyc("fill2", 1, 9, 2, 0, 1);
    chk("fill2.lv", 32'(bus.load_voice), 32'b100);
    chk("fill2.notes", 32'(bus.voice_note), 32'({6'd9, 6'd7, 6'd5}));
    chk("fill2.active", 32'(bus.voice_active), 32'b111);
    cyc("steal", 1, 12, 4, 0, 1);
    chk("steal.lv", 32'(bus.load_voice), 32'b100);
    chk("steal.pulse", 32'(bus.steal), 32'd1);
    chk("steal.note2", 32'(bus.voice_note[17:12]), 32'd12);
    for (int i = 0; i < 5; i++) cyc("drain1", 0, 0, 0, 1, 1);
    chk("drain1.idle", 32'(bus.all_idle), 32'd1);

    cyc("exp_load", 1, 3, 2, 0, 1);
    cyc("exp_b1", 0, 0, 0, 1, 1);
    chk("exp_b1.chord", 32'(bus.chord_done), 32'd0);
    cyc("exp_b2", 0, 0, 0, 1, 1);
    chk("exp_b2.active", 32'(bus.voice_active), 32'b000);
    chk("exp_b2.chord", 32'(bus.chord_done), 32'd1);
    cyc("exp_after", 0, 0, 0, 0, 1);
    chk("exp_after.chord", 32'(bus.chord_done), 32'd0);

    cyc("pause_load", 1, 4, 3, 0, 1);
    for (int i = 0; i < 5; i++) cyc("paused", 0, 0, 0, 1, 0);
    chk("paused.active", 32'(bus.voice_active), 32'b001);
    for (int i = 0; i < 3; i++) cyc("resume", 0, 0, 0, 1, 1);
    chk("resume.idle", 32'(bus.all_idle), 32'd1);

    cyc("sim0", 1, 1, 6, 0, 1);
    cyc("sim1", 1, 2, 2, 0, 1);
    cyc("sim2", 1, 3, 6, 0, 1);
    cyc("sim_beat", 0, 0, 0, 1, 1);
    cyc("simul", 1, 20, 6, 1, 1);
    chk("simul.lv", 32'(bus.load_voice), 32'b010);
    chk("simul.steal", 32'(bus.steal), 32'd0);
    chk("simul.chord", 32'(bus.chord_done), 32'd0);
    for (int i = 0; i < 6; i++) cyc("drain2", 0, 0, 0, 1, 1);

    cyc("rest", 1, 0, 4, 0, 1);
    chk("rest.lv", 32'(bus.load_voice), 32'd0);
    chk("rest.drop", 32'(bus.drop), 32'd0);
    cyc("zero", 1, 8, 0, 0, 1);
    chk("zero.drop", 32'(bus.drop), 32'd1);
    chk("zero.idle", 32'(bus.all_idle), 32'd1);

    for (int k = 0; k < 400; k++) begin
      int n, d;
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      d = ($urandom_range(0, 7) == 0 && n != 0) ? 0 : int'($urandom_range(1, 6));
      cyc("rand", $urandom_range(0, 2) == 0, n, d, $urandom_range(0, 1) == 1,
          $urandom_range(0, 4) != 0);
    end

    cyc("mid_load", 1, 33, 9, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post_reset", 1, 17, 2, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
